// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative HI/LO multiply/divide unit for the EX stage.
// An operation is accepted in IDLE and then runs through a load cycle,
// 32 iteration cycles (shift-add or restoring shift-subtract) and one
// FIX cycle. The FIX cycle applies sign correction and writes HI/LO.
// MTHI/MTLO writes are accepted only while the unit is idle. Any
// request that arrives while busy raises stall so the front end holds.
module ex_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] mt_data,
    input  logic        hilo_rd,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    // Iteration counter. Six bits hold the full range of 32 steps.
    logic [5:0]  count;

    // The multiply uses this as the multiplicand magnitude.
    // The divide uses this as the divisor magnitude.
    logic [31:0] operand;

    // The multiply keeps {partial high, multiplier/low product} here.
    // The divide keeps {remainder, dividend shifting into quotient} here.
    logic [63:0] acc;

    logic        neg_res;
    logic        neg_rem;
    logic        is_div;
    logic        div_zero;
    logic [31:0] dividend_raw;

    logic        op_signed;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic        last_step;

    logic [32:0] mul_sum;
    logic [32:0] div_partial;
    logic        div_fits;
    logic [31:0] div_diff;

    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign busy      = (state != IDLE);
    assign stall     = busy & (start | hilo_rd | hi_we | lo_we);
    assign last_step = (count == 6'd31);

    // Take operand magnitudes for the signed ops. The unsigned ops pass rs and rt through unchanged.
    always_comb begin
        op_signed = ~op[0];
        rs_mag    = (op_signed & rs[31]) ? (32'd0 - rs) : rs;
        rt_mag    = (op_signed & rt[31]) ? (32'd0 - rt) : rt;
    end

    // Single iteration of multiply (add-then-shift) and of restoring divide (shift-then-try-subtract).
    always_comb begin
        mul_sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        div_partial = acc[63:31];
        div_fits    = (div_partial >= {1'b0, operand});
        div_diff    = div_partial[31:0] - operand;
    end

    // Sign-corrected results that the FIX cycle commits to HI/LO.
    always_comb begin
        prod_fix = neg_res ? (64'd0 - acc) : acc;
        quo_fix  = neg_res ? (32'd0 - acc[31:0]) : acc[31:0];
        rem_fix  = neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];
    end

    // State register. Reset abandons any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A start that arrives while busy is ignored because only IDLE looks at it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = op[1] ? DIV : MUL;
                end
            end
            MUL: begin
                if (last_step) begin
                    state_next = FIX;
                end
            end
            DIV: begin
                if (last_step) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch on start, then one multiply or divide step per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count        <= 6'd0;
            operand      <= 32'd0;
            acc          <= 64'd0;
            neg_res      <= 1'b0;
            neg_rem      <= 1'b0;
            is_div       <= 1'b0;
            div_zero     <= 1'b0;
            dividend_raw <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count        <= 6'd0;
                        is_div       <= op[1];
                        neg_res      <= op_signed & (rs[31] ^ rt[31]);
                        neg_rem      <= op_signed & rs[31];
                        div_zero     <= (rt == 32'd0);
                        dividend_raw <= rs;
                        if (op[1]) begin
                            operand <= rt_mag;
                            acc     <= {32'd0, rs_mag};
                        end else begin
                            operand <= rs_mag;
                            acc     <= {32'd0, rt_mag};
                        end
                    end
                end
                MUL: begin
                    count <= count + 6'd1;
                    acc   <= {mul_sum, acc[31:1]};
                end
                DIV: begin
                    count <= count + 6'd1;
                    if (div_fits) begin
                        acc <= {div_diff, acc[30:0], 1'b1};
                    end else begin
                        acc <= {div_partial[31:0], acc[30:0], 1'b0};
                    end
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

    // HI/LO only change on the FIX commit or on an MT write accepted in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (state == FIX) begin
            if (!is_div) begin
                hi <= prod_fix[63:32];
                lo <= prod_fix[31:0];
            end else if (div_zero) begin
                hi <= dividend_raw;
                lo <= 32'hFFFF_FFFF;
            end else begin
                hi <= rem_fix;
                lo <= quo_fix;
            end
        end else if (state == IDLE) begin
            if (hi_we) begin
                hi <= mt_data;
            end
            if (lo_we) begin
                lo <= mt_data;
            end
        end
    end

    // Completion pulse. It goes high for the single cycle after the FIX commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done <= 1'b0;
        end else begin
            done <= (state == FIX);
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and randomized checks of ex_muldiv against an arithmetic model.
module tb_ex_muldiv;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] mt_data;
    logic        hilo_rd;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] modelHi = 32'd0;
    logic [31:0] modelLo = 32'd0;

    ex_muldiv dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs      (rs),
        .rt      (rt),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .mt_data (mt_data),
        .hilo_rd (hilo_rd),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .stall   (stall),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result {HI, LO}, computed with plain arithmetic.
    function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin
                p = 64'(sa * sb);
                return p;
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                return p;
            end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Run one operation. Check that HI/LO hold during the run and that the result and done arrive on edge 34.
    task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [63:0] exp);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rs    = $urandom;
        rt    = $urandom;
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        repeat (32) @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_hold_hi"}, hi, modelHi);
        checkOutput({tag, "_hold_lo"}, lo, modelLo);
        checkOutput({tag, "_early_done"}, 32'(done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        modelHi = exp[63:32];
        modelLo = exp[31:0];
        checkOutput({tag, "_hi"}, hi, modelHi);
        checkOutput({tag, "_lo"}, lo, modelLo);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_done_drop"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] firstRes;

        reset   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        rs      = 32'd0;
        rt      = 32'd0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        mt_data = 32'd0;
        hilo_rd = 1'b0;

        $display("[TB] reset state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        reset = 1'b1;

        $display("[TB] MT writes in idle");
        @(negedge clk);
        hi_we   = 1'b1;
        mt_data = 32'h0000_1234;
        #1 checkOutput("mthi_stall", 32'(stall), 32'd0);
        @(negedge clk);
        hi_we   = 1'b0;
        modelHi = 32'h0000_1234;
        checkOutput("mthi_hi", hi, modelHi);
        lo_we   = 1'b1;
        mt_data = 32'h0BAD_F00D;
        @(negedge clk);
        lo_we   = 1'b0;
        modelLo = 32'h0BAD_F00D;
        checkOutput("mtlo_lo", lo, modelLo);

        $display("[TB] directed operations");
        applyStimulus("mult_neg2x3", 2'b00, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        applyStimulus("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
        applyStimulus("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        applyStimulus("divu_7_0", 2'b11, 32'd7, 32'd0, {32'd7, 32'hFFFF_FFFF});
        applyStimulus("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});

        $display("[TB] randomized operations");
        for (int i = 0; i < 12; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            if (i % 4 == 1) ra = 32'd0 - 32'($urandom_range(1, 100000));
            applyStimulus($sformatf("rand%0d", i), rop, ra, rb, refModel(rop, ra, rb));
        end

        $display("[TB] busy interactions");
        firstRes = refModel(2'b00, 32'h1234_5678, 32'hFFFF_FF00);
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        rs    = 32'h1234_5678;
        rt    = 32'hFFFF_FF00;
        @(posedge clk);
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            start   = (c == 5);
            op      = (c == 5) ? 2'b11 : 2'b00;
            rs      = (c == 5) ? 32'd100 : 32'd0;
            rt      = (c == 5) ? 32'd7 : 32'd0;
            lo_we   = (c == 7);
            mt_data = 32'hDEAD_BEEF;
            hilo_rd = (c >= 10);
            #1;
            if (c == 5 || c == 7 || c >= 10) begin
                checkOutput($sformatf("busy_stall_c%0d", c), 32'(stall), 32'd1);
            end else begin
                checkOutput($sformatf("busy_nostall_c%0d", c), 32'(stall), 32'd0);
            end
            if (c == 8) checkOutput("busy_mtlo_ignored", lo, modelLo);
            @(posedge clk);
        end
        @(negedge clk);
        hilo_rd = 1'b0;
        lo_we   = 1'b0;
        modelHi = firstRes[63:32];
        modelLo = firstRes[31:0];
        checkOutput("busy_first_hi", hi, modelHi);
        checkOutput("busy_first_lo", lo, modelLo);
        checkOutput("busy_done", 32'(done), 32'd1);
        #1 checkOutput("busy_idle_stall", 32'(stall), 32'd0);
        @(negedge clk);
        checkOutput("busy_no_second_op", 32'(busy), 32'd0);

        $display("[TB] reset mid-operation");
        @(negedge clk);
        hi_we   = 1'b1;
        lo_we   = 1'b1;
        mt_data = 32'hAAAA_5555;
        @(negedge clk);
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        start   = 1'b1;
        op      = 2'b01;
        rs      = 32'h0000_FFFF;
        rt      = 32'h0000_0FFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput("mid_pre_hi", hi, 32'hAAAA_5555);
        repeat (10) @(posedge clk);
        @(negedge clk);
        hilo_rd = 1'b1;
        #1 checkOutput("mid_pre_stall", 32'(stall), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("mid_busy", 32'(busy), 32'd0);
        checkOutput("mid_hi", hi, 32'd0);
        checkOutput("mid_lo", lo, 32'd0);
        checkOutput("mid_stall", 32'(stall), 32'd0);
        checkOutput("mid_done", 32'(done), 32'd0);
        modelHi = 32'd0;
        modelLo = 32'd0;
        @(negedge clk);
        reset   = 1'b1;
        hilo_rd = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checkOutput($sformatf("post_rst_done%0d", c), 32'(done), 32'd0);
            checkOutput($sformatf("post_rst_busy%0d", c), 32'(busy), 32'd0);
        end
        checkOutput("post_rst_hi", hi, modelHi);
        checkOutput("post_rst_lo", lo, modelLo);

        $display("[TB] fresh operation after reset");
        applyStimulus("after_rst", 2'b01, 32'h0001_0000, 32'h0001_0000, {32'd1, 32'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
